// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI4-Stream frame checker.
// Holds the FSM state encoding, error-bit indices and counter width.
package axis_chk_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam int ERR_LEN   = 0;
    localparam int ERR_USER  = 1;
    localparam int ERR_KEEP  = 2;
    localparam int ERR_OVF   = 3;
    localparam int ERR_WIDTH = 4;

    localparam int CNT_WIDTH = 32;

endpackage

// File: rtl/axis_keep_decode.sv
// Combinational tkeep decoder: byte count and lane-pattern flags.
// Ports: i_keep in; o_popcount, o_all_ones, o_contig_lsb out.
module axis_keep_decode #(
    parameter int KEEP_WIDTH = 4,
    parameter int POP_WIDTH  = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0] i_keep,
    output logic [POP_WIDTH-1:0]  o_popcount,
    output logic                  o_all_ones,
    output logic                  o_contig_lsb
);

    logic [KEEP_WIDTH-1:0] w_keep_inc;

    always_comb begin
        o_popcount = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            o_popcount = o_popcount + POP_WIDTH'(i_keep[i]);
        end
    end

    // 0..01..1 patterns are exactly those with keep & (keep+1) == 0
    assign w_keep_inc   = i_keep + KEEP_WIDTH'(1);
    assign o_all_ones   = &i_keep;
    assign o_contig_lsb = (|i_keep) && ((i_keep & w_keep_inc) == '0);

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream endpoint: counts beats/bytes per frame, flags errors and
// emits one status record per frame. Ports: s_axis_* stream in,
// cfg_len expected beats, m_stat_* record out, frame/error counters.
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  m_stat_valid,
    input  logic                  m_stat_ready,
    output logic [LEN_WIDTH-1:0]  m_stat_beats,
    output logic [LEN_WIDTH+$clog2(KEEP_WIDTH)-1:0] m_stat_bytes,
    output logic [ERR_WIDTH-1:0]  m_stat_err,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  err_frame_count
);

    localparam int BW = LEN_WIDTH + $clog2(KEEP_WIDTH);
    localparam int PW = $clog2(KEEP_WIDTH + 1);

    state_t                 r_state;
    logic                   r_rstn_q;
    logic [LEN_WIDTH-1:0]   r_cfg;
    logic [LEN_WIDTH-1:0]   r_beats;
    logic [BW-1:0]          r_bytes;
    logic                   r_user;
    logic                   r_keep;
    logic                   r_ovf;
    logic                   r_stat_valid;
    logic [LEN_WIDTH-1:0]   r_stat_beats;
    logic [BW-1:0]          r_stat_bytes;
    logic [ERR_WIDTH-1:0]   r_stat_err;
    logic [CNT_WIDTH-1:0]   r_frame_cnt;
    logic [CNT_WIDTH-1:0]   r_err_cnt;

    logic [PW-1:0]          w_pop;
    logic                   w_all_ones;
    logic                   w_contig;
    logic                   w_tready;
    logic                   w_accept;
    logic                   w_first;
    logic [LEN_WIDTH-1:0]   w_cfg;
    logic [LEN_WIDTH-1:0]   w_base_beats;
    logic [BW-1:0]          w_base_bytes;
    logic [LEN_WIDTH-1:0]   w_nx_beats;
    logic [BW:0]            w_bytes_sum;
    logic [BW-1:0]          w_nx_bytes;
    logic [PW-1:0]          w_add;
    logic                   w_beat_keep_err;
    logic                   w_nx_user;
    logic                   w_nx_keep;
    logic                   w_nx_ovf;
    logic [ERR_WIDTH-1:0]   w_err;
    logic                   w_unused;

    axis_keep_decode #(
        .KEEP_WIDTH (KEEP_WIDTH),
        .POP_WIDTH  (PW)
    ) u_keep (
        .i_keep       (s_axis_tkeep),
        .o_popcount   (w_pop),
        .o_all_ones   (w_all_ones),
        .o_contig_lsb (w_contig)
    );

    assign w_unused = ^{s_axis_tdata, s_axis_tuser};

    assign w_tready = r_rstn_q && (!r_stat_valid || m_stat_ready);
    assign w_accept = s_axis_tvalid && w_tready;

    // First beat of a frame starts from zero and latches cfg_len
    assign w_first      = (r_state == IDLE);
    assign w_cfg        = w_first ? cfg_len : r_cfg;
    assign w_base_beats = w_first ? '0 : r_beats;
    assign w_base_bytes = w_first ? '0 : r_bytes;

    assign w_nx_beats = (&w_base_beats) ? w_base_beats
                      : w_base_beats + LEN_WIDTH'(1);

    assign w_add       = (KEEP_ENABLE != 0) ? w_pop : PW'(KEEP_WIDTH);
    assign w_bytes_sum = {1'b0, w_base_bytes} + (BW+1)'(w_add);
    assign w_nx_bytes  = w_bytes_sum[BW] ? '1 : w_bytes_sum[BW-1:0];

    // Last beat may be partial but must fill lanes from the LSB
    assign w_beat_keep_err = (KEEP_ENABLE != 0) &&
                             (s_axis_tlast ? !w_contig : !w_all_ones);

    assign w_nx_user = (!w_first && r_user) || s_axis_tuser[0];
    assign w_nx_keep = (!w_first && r_keep) || w_beat_keep_err;
    assign w_nx_ovf  = (!w_first && r_ovf) || (&w_nx_beats);

    always_comb begin
        w_err           = '0;
        w_err[ERR_LEN]  = (w_cfg != '0) && (w_nx_beats != w_cfg);
        w_err[ERR_USER] = w_nx_user;
        w_err[ERR_KEEP] = w_nx_keep;
        w_err[ERR_OVF]  = w_nx_ovf;
    end

    always_ff @(posedge clk) begin
        r_rstn_q <= rstn;
        if (!rstn) begin
            r_state      <= IDLE;
            r_cfg        <= '0;
            r_beats      <= '0;
            r_bytes      <= '0;
            r_user       <= 1'b0;
            r_keep       <= 1'b0;
            r_ovf        <= 1'b0;
            r_stat_valid <= 1'b0;
            r_stat_beats <= '0;
            r_stat_bytes <= '0;
            r_stat_err   <= '0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
        end else begin
            if (r_stat_valid && m_stat_ready) begin
                r_stat_valid <= 1'b0;
            end
            if (w_accept) begin
                if (s_axis_tlast) begin
                    r_state      <= IDLE;
                    r_stat_valid <= 1'b1;
                    r_stat_beats <= w_nx_beats;
                    r_stat_bytes <= w_nx_bytes;
                    r_stat_err   <= w_err;
                    r_frame_cnt  <= r_frame_cnt + CNT_WIDTH'(1);
                    if (|w_err) begin
                        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                    end
                    r_beats <= '0;
                    r_bytes <= '0;
                    r_user  <= 1'b0;
                    r_keep  <= 1'b0;
                    r_ovf   <= 1'b0;
                end else begin
                    r_state <= BODY;
                    r_cfg   <= w_cfg;
                    r_beats <= w_nx_beats;
                    r_bytes <= w_nx_bytes;
                    r_user  <= w_nx_user;
                    r_keep  <= w_nx_keep;
                    r_ovf   <= w_nx_ovf;
                end
            end
        end
    end

    assign s_axis_tready   = w_tready;
    assign m_stat_valid    = r_stat_valid;
    assign m_stat_beats    = r_stat_beats;
    assign m_stat_bytes    = r_stat_bytes;
    assign m_stat_err      = r_stat_err;
    assign frame_count     = r_frame_cnt;
    assign err_frame_count = r_err_cnt;

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

AXI4-Stream receive-end terminator: consumes the output stream of the accelerator (typically fed by an `axis_register` stage in front of the output DMA) and emits one status record per frame, with beat/byte counts and error flags. Sits at stream endpoints for on-chip self-check and bring-up. The block keeps data flowing without bubbles while the status path accepts records.

## Interface
- `DATA_WIDTH`, 8, stream data width in bits.
- `KEEP_ENABLE`, (DATA_WIDTH>8), use `s_axis_tkeep`; when 0, every beat counts as full.
- `KEEP_WIDTH`, DATA_WIDTH/8, byte lanes per beat.
- `USER_WIDTH`, 1, tuser width; only bit 0 is checked.
- `LEN_WIDTH`, 16, width of the beat counter and `cfg_len`.
- `clk`  in  1  single clock, all logic on rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_axis_tdata`  in  DATA_WIDTH  data, ignored apart from handshake.
- `s_axis_tkeep`  in  KEEP_WIDTH  byte enables.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accept.
- `s_axis_tlast`  in  1  end of frame.
- `s_axis_tuser`  in  USER_WIDTH  bit 0 = upstream error marker.
- `cfg_len`  in  LEN_WIDTH  expected beats per frame; 0 disables the length check.
- `m_stat_valid`  out  1  status record valid.
- `m_stat_ready`  in  1  status record accept.
- `m_stat_beats`  out  LEN_WIDTH  beats in frame, saturating.
- `m_stat_bytes`  out  LEN_WIDTH+$clog2(KEEP_WIDTH)  bytes in frame, saturating.
- `m_stat_err`  out  4  {ovf, keep, user, len}, bit 0 = len.
- `frame_count`  out  32  frames reported, wrapping.
- `err_frame_count`  out  32  frames with any `m_stat_err` bit set, wrapping.

## Operation
- Accept: beat accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready = rstn_q && (!m_stat_valid || m_stat_ready)`. `rstn_q` is a registered copy of `rstn`, so ready is low during reset and for the first cycle after it.
- FSM `IDLE` means no beat of the current frame has been accepted yet. `BODY` means at least one beat has been accepted and tlast has not been seen.
  - In `IDLE`, an accepted beat latches `cfg_len`, initialises the accumulators from that beat, and moves to `BODY` if tlast=0.
  - In `BODY`, an accepted beat updates the accumulators; tlast=1 returns the FSM to `IDLE`.
  - A single-beat frame stays in `IDLE`.
- Accumulators:
  - beats += 1, saturating at all-ones. Reaching saturation sets `ovf`.
  - bytes += popcount(tkeep), or KEEP_WIDTH when KEEP_ENABLE=0, saturating.
  - user |= tuser[0].
  - keep is set by a non-last beat with tkeep not all-ones, or a last beat whose tkeep is zero or not contiguous from the LSB (e.g. 4'b0110).
  - Keep checks are skipped when KEEP_ENABLE=0.
- On the tlast acceptance:
  - Final values, including the current beat, load into the status register and `m_stat_valid` is set.
  - len is set when the latched cfg_len ≠ 0 and the final beats ≠ the latched cfg_len.
  - `frame_count` increments; `err_frame_count` increments if any error bit is set.
  - The accumulators clear for the next frame.
- Status register: holds until `m_stat_ready`. A new tlast in the same cycle as `m_stat_ready` overwrites it, with no bubble.
- Reset values: `s_axis_tready` 0, `m_stat_valid` 0, `m_stat_beats` 0, `m_stat_bytes` 0, `m_stat_err` 0, both counters 0, FSM `IDLE`. A reset in the middle of a frame discards the partial frame without reporting it.

## Timing
- Status latency: `m_stat_valid` rises 1 cycle after the tlast beat is accepted.
- Throughput: one beat per cycle while the status path is not stalled.
- Back-pressure: with `m_stat_valid`=1 and `m_stat_ready`=0, `s_axis_tready` is 0, so at most one unread record exists.
- Combinational path: `m_stat_ready` → `s_axis_tready` (one gate). This is the only such path.
- Counters become visible in the same cycle as `m_stat_valid`.

## Structure
- Package `axis_chk_pkg`:
  - FSM state encoding (`IDLE`, `BODY`).
  - Error bit indices `ERR_LEN`=0, `ERR_USER`=1, `ERR_KEEP`=2, `ERR_OVF`=3.
  - Counter width 32.
- Sub-module `axis_keep_decode`: combinational, KEEP_WIDTH in; outputs popcount, all_ones and contiguous_lsb. Instantiated once.

## Test plan
- cfg_len=4, KEEP_WIDTH=4, four full beats with tlast on beat 4 → beats=4, bytes=16, err=0, frame_count=1, record valid 1 cycle after beat 4.
- cfg_len=4, frame of 3 beats whose last tkeep is 4'b0011 → beats=3, bytes=10, err=4'b0001, err_frame_count=1.
- Single-beat frame with tkeep=4'b0110, tuser=1 → beats=1, bytes=2, err=4'b0110; FSM stays `IDLE`.
- Hold `m_stat_ready`=0 after frame 1 → `s_axis_tready`=0 and frame 2 stalls. Raise ready in the cycle frame 2's last beat is presented → no bubble, and the record updates to frame 2 on the next cycle.
- LEN_WIDTH=4, 20-beat frame → beats=15, err has ovf set.
- Assert rstn=0 on beat 2 of a 5-beat frame, then send a 2-beat frame → the first record reports beats=2 and frame_count=1.
